memctrl_bist_engine: RTL and testbench

//  March C- BIST engine that sits directly upstream of MEMCTRL and drives its SRAM-style

---
 rtl/memctrl_bist_engine.sv | 170 +++++++++++++++++
 tb/tb_memctrl_bist_engine.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memctrl_bist_engine.sv
// March C- BIST master for MEMCTRL: sequences the six March elements over the SRAM-style
// bus, checks every read against the expected background and latches the first mismatch.
module memctrl_bist_engine #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] ADDR_MAX = 16'hFFFF
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              BIST_START,
  output logic              BIST_BUSY,
  output logic              BIST_DONE,
  output logic              BIST_FAIL,
  output logic [ADDR_W-1:0] FAIL_ADDR,
  output logic [DATA_W-1:0] FAIL_DATA,
  output logic [2:0]        FAIL_ELEM,
  output logic [ADDR_W-1:0] ADDR,
  output logic              CE,
  output logic              CSB,
  output logic              WEB,
  output logic              OEB,
  output logic [DATA_W-1:0] IDATA,
  input  logic [DATA_W-1:0] ODATA
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_RELEASE, S_DONE} state_t;

  state_t            state_reg;
  logic [2:0]        elem_reg;
  logic              op_reg;
  logic [ADDR_W-1:0] addr_reg;

  // Two-op elements are always (read, write); E0 is a lone write, E5 a lone read.
  function automatic logic op_wr(input logic [2:0] e, input logic o);
    case (e)
      3'd0:    op_wr = 1'b1;
      3'd5:    op_wr = 1'b0;
      default: op_wr = o;
    endcase
  endfunction

  function automatic logic op_val(input logic [2:0] e, input logic o);
    case (e)
      3'd1, 3'd3: op_val = o;
      3'd2, 3'd4: op_val = ~o;
      default:    op_val = 1'b0;
    endcase
  endfunction

  function automatic logic is_two_op(input logic [2:0] e);
    is_two_op = (e != 3'd0) && (e != 3'd5);
  endfunction

  function automatic logic is_dn(input logic [2:0] e);
    is_dn = (e == 3'd3) || (e == 3'd4);
  endfunction

  logic              at_end, adv_op, adv_last, go_setup, mismatch;
  logic [2:0]        adv_elem, elem_inc, tgt_elem;
  logic [ADDR_W-1:0] adv_addr, tgt_addr;
  logic              tgt_op, tgt_wr;
  logic [DATA_W-1:0] tgt_data, exp_data;

  always_comb begin
    elem_inc = elem_reg + 3'd1;
    at_end   = is_dn(elem_reg) ? (addr_reg == '0) : (addr_reg == ADDR_MAX);
    adv_elem = elem_reg;
    adv_op   = op_reg;
    adv_addr = addr_reg;
    adv_last = 1'b0;
    if (is_two_op(elem_reg) && !op_reg) begin
      adv_op = 1'b1;
    end else if (!at_end) begin
      adv_op   = 1'b0;
      adv_addr = is_dn(elem_reg) ? addr_reg - ADDR_W'(1) : addr_reg + ADDR_W'(1);
    end else if (elem_reg == 3'd5) begin
      adv_last = 1'b1;
    end else begin
      adv_elem = elem_inc;
      adv_op   = 1'b0;
      adv_addr = is_dn(elem_inc) ? ADDR_MAX : '0;
    end

    exp_data = {DATA_W{op_val(elem_reg, op_reg)}};
    mismatch = (state_reg == S_RELEASE) && !op_wr(elem_reg, op_reg) && (ODATA != exp_data);

    // A start always targets E0/op0/addr 0; otherwise the next op comes from the sequencer.
    go_setup = (((state_reg == S_IDLE) || (state_reg == S_DONE)) && BIST_START) ||
               ((state_reg == S_RELEASE) && !mismatch && !adv_last);
    tgt_elem = (state_reg == S_RELEASE) ? adv_elem : 3'd0;
    tgt_op   = (state_reg == S_RELEASE) ? adv_op   : 1'b0;
    tgt_addr = (state_reg == S_RELEASE) ? adv_addr : '0;
    tgt_wr   = op_wr(tgt_elem, tgt_op);
    tgt_data = {DATA_W{op_val(tgt_elem, tgt_op)}};
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_reg <= S_IDLE;
      elem_reg  <= 3'd0;
      op_reg    <= 1'b0;
      addr_reg  <= '0;
      BIST_BUSY <= 1'b0;
      BIST_DONE <= 1'b0;
      BIST_FAIL <= 1'b0;
      FAIL_ADDR <= '0;
      FAIL_DATA <= '0;
      FAIL_ELEM <= 3'd0;
      ADDR      <= '0;
      CE        <= 1'b0;
      CSB       <= 1'b1;
      WEB       <= 1'b1;
      OEB       <= 1'b1;
      IDATA     <= '0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (BIST_START) begin
            BIST_BUSY <= 1'b1;
            BIST_DONE <= 1'b0;
            BIST_FAIL <= 1'b0;
            FAIL_ADDR <= '0;
            FAIL_DATA <= '0;
            FAIL_ELEM <= 3'd0;
          end
        end
        S_SETUP: begin
          CE        <= 1'b1;
          state_reg <= S_STROBE;
        end
        S_STROBE: begin
          CE        <= 1'b0;
          CSB       <= 1'b1;
          WEB       <= 1'b1;
          IDATA     <= '0;
          state_reg <= S_RELEASE;
        end
        S_RELEASE: begin
          if (mismatch) begin
            BIST_FAIL <= 1'b1;
            FAIL_ADDR <= addr_reg;
            FAIL_DATA <= ODATA;
            FAIL_ELEM <= elem_reg;
          end
          if (mismatch || adv_last) begin
            BIST_BUSY <= 1'b0;
            BIST_DONE <= 1'b1;
            OEB       <= 1'b1;
            state_reg <= S_DONE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase

      if (go_setup) begin
        state_reg <= S_SETUP;
        elem_reg  <= tgt_elem;
        op_reg    <= tgt_op;
        addr_reg  <= tgt_addr;
        ADDR      <= tgt_addr;
        CSB       <= 1'b0;
        CE        <= 1'b0;
        WEB       <= ~tgt_wr;
        OEB       <= tgt_wr;
        IDATA     <= tgt_wr ? tgt_data : '0;
      end
    end
  end

endmodule

// File: tb/tb_memctrl_bist_engine.sv
// Bench for memctrl_bist_engine with a 4-word behavioural MEMCTRL and fault injection;
// expected bus ops and results come from a March C- walk over a plain array.
module tb_memctrl_bist_engine;
  localparam int AMAX = 3;

  logic        clk = 1'b0;
  logic        rstn, start;
  logic        busy, done, fail, ce, csb, web, oeb;
  logic [15:0] fail_addr, addr;
  logic [7:0]  fail_data, idata;
  logic [7:0]  odata = 8'h00;
  logic [2:0]  fail_elem;

  always #5 clk = ~clk;

  memctrl_bist_engine #(.ADDR_W(16), .DATA_W(8), .ADDR_MAX(16'd3)) dut (
    .CLK(clk), .RSTN(rstn), .BIST_START(start),
    .BIST_BUSY(busy), .BIST_DONE(done), .BIST_FAIL(fail),
    .FAIL_ADDR(fail_addr), .FAIL_DATA(fail_data), .FAIL_ELEM(fail_elem),
    .ADDR(addr), .CE(ce), .CSB(csb), .WEB(web), .OEB(oeb),
    .IDATA(idata), .ODATA(odata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Fault: kind 0 none, 1 stuck bit f_bit of f_addr at f_val, 2 drop 00-writes to f_addr once it held FF.
  int   f_kind = 0, f_addr = 0, f_bit = 0;
  logic f_val = 1'b0;

  function automatic logic [7:0] rd_fault(input logic [7:0] s, input int a);
    logic [7:0] r;
    r = s;
    if (f_kind == 1 && a == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  function automatic logic drop_wr(input int a, input logic [7:0] d, input logic seen);
    return (f_kind == 2) && (a == f_addr) && (d == 8'h00) && seen;
  endfunction

  // Behavioural MEMCTRL: write or read on a CE strobe; read data held until the next read.
  logic [7:0] bus_mem [4];
  logic       bus_seen = 1'b0;
  always @(posedge clk) begin
    if (start) bus_seen <= 1'b0;
    if (ce && !csb) begin
      if (!web) begin
        if (!drop_wr(int'(addr), idata, bus_seen)) bus_mem[addr[1:0]] <= idata;
        if (int'(addr) == f_addr && idata == 8'hFF) bus_seen <= 1'b1;
      end
      if (!oeb) odata <= rd_fault(bus_mem[addr[1:0]], int'(addr));
    end
  end

  typedef struct packed {
    logic [15:0] a;
    logic        wr;
    logic [7:0]  d;
  } op_t;
  op_t exp_q[$];
  bit  mon_en = 1'b0;

  // March C- table: ops per element, write flag and data bit per op, descending flag.
  int       nops [6] = '{1, 2, 2, 2, 2, 1};
  bit [1:0] mwr  [6] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
  bit [1:0] mval [6] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00};
  int       mdn  [6] = '{0, 0, 0, 1, 1, 0};

  task automatic model_run(output bit ef, output int ea, output logic [7:0] ed,
                           output int ee, output int ecyc);
    logic [7:0] m [4];
    bit         seen = 1'b0;
    bit         stop = 1'b0;
    int         ops = 0;
    int         a;
    logic [7:0] d, r;
    ef = 1'b0; ea = 0; ed = 8'h00; ee = 0;
    exp_q.delete();
    for (int e = 0; e < 6 && !stop; e++) begin
      for (int k = 0; k <= AMAX && !stop; k++) begin
        a = (mdn[e] != 0) ? AMAX - k : k;
        for (int o = 0; o < nops[e] && !stop; o++) begin
          ops++;
          d = mval[e][o] ? 8'hFF : 8'h00;
          exp_q.push_back({16'(a), mwr[e][o], d});
          if (mwr[e][o]) begin
            if (!drop_wr(a, d, seen)) m[a] = d;
            if (a == f_addr && d == 8'hFF) seen = 1'b1;
          end else begin
            r = rd_fault(m[a], a);
            if (r !== d) begin
              ef = 1'b1; ea = a; ed = r; ee = e; stop = 1'b1;
            end
          end
        end
      end
    end
    ecyc = ops * 3;
  endtask

  task automatic check_op(input op_t e);
    chk("op_addr", 32'(addr), 32'(e.a));
    chk("op_web", 32'(web), 32'(!e.wr));
    chk("op_oeb", 32'(oeb), 32'(e.wr));
    chk("op_idata", 32'(idata), e.wr ? 32'(e.d) : 32'd0);
  endtask

  logic        p_csb, p_ce, p_web, p_oeb;
  logic [15:0] p_addr;
  logic [7:0]  p_idata;
  always @(negedge clk) begin
    if (mon_en) begin
      chk("web_oeb_exclusive", 32'(!web && !oeb), 32'd0);
      if (ce) begin
        chk("ce_with_csb", 32'(csb), 32'd0);
        chk("setup_before_strobe", {30'd0, p_csb, p_ce}, 32'd0);
        chk("stable_setup_strobe", {p_addr, p_idata, p_web, p_oeb},
            {addr, idata, web, oeb});
        if (exp_q.size() == 0) chk("op_extra", 32'd1, 32'd0);
        else check_op(exp_q.pop_front());
      end
    end
    p_csb   <= csb;
    p_ce    <= ce;
    p_web   <= web;
    p_oeb   <= oeb;
    p_addr  <= addr;
    p_idata <= idata;
  end

  task automatic check_idle(input string tag);
    chk({tag, "_csb"}, 32'(csb), 32'd1);
    chk({tag, "_ce"}, 32'(ce), 32'd0);
    chk({tag, "_web"}, 32'(web), 32'd1);
    chk({tag, "_oeb"}, 32'(oeb), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Pulses start and counts busy cycles; optional extra start pulse or reset at a given cycle.
  task automatic do_run(input int extra_at, input int abort_at, output int cyc, output bit aborted);
    aborted = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("done_cleared", 32'(done), 32'd0);
    chk("fail_cleared", 32'(fail), 32'd0);
    while (busy && cyc < 1000) begin
      cyc++;
      if (cyc == abort_at) begin
        #3 rstn = 1'b0; mon_en = 1'b0;
        #1 check_idle("abort");
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_addr", 32'(addr), 32'd0);
        exp_q.delete();
        @(negedge clk); rstn = 1'b1;
        aborted = 1'b1;
        break;
      end
      start = (cyc == extra_at);
      @(negedge clk);
    end
    start = 1'b0;
    if (cyc >= 1000) chk("run_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_check(input string tag, input int extra_at, input bit ef, input int ea,
                           input logic [7:0] ed, input int ee, input int ecyc);
    int cyc;
    bit ab;
    mon_en = 1'b1;
    do_run(extra_at, -1, cyc, ab);
    chk({tag, "_cycles"}, 32'(cyc), 32'(ecyc));
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_fail"}, 32'(fail), 32'(ef));
    chk({tag, "_fail_addr"}, 32'(fail_addr), 32'(ea));
    chk({tag, "_fail_data"}, 32'(fail_data), 32'(ed));
    chk({tag, "_fail_elem"}, 32'(fail_elem), 32'(ee));
    chk({tag, "_ops_left"}, 32'(exp_q.size()), 32'd0);
    check_idle({tag, "_end"});
    repeat (3) @(negedge clk);
    chk({tag, "_done_sticky"}, 32'(done), 32'd1);
    mon_en = 1'b0;
    $display("run %s: kind=%0d addr=%0d bit=%0d val=%0d cycles=%0d fail=%0d fail_addr=%0d fail_data=%02h fail_elem=%0d",
             tag, f_kind, f_addr, f_bit, f_val, cyc, fail, fail_addr, fail_data, fail_elem);
  endtask

  typedef struct {
    int         kind, fa, fb;
    logic       fv;
    bit         efail;
    int         eaddr;
    logic [7:0] edata;
    int         eelem, ecyc;
  } vec_t;

  initial begin
    vec_t       vecs [3];
    bit         ef, ab;
    int         ea, ee, ecyc, cyc;
    logic [7:0] ed;

    vecs[0] = '{kind: 0, fa: 0, fb: 0, fv: 1'b0, efail: 1'b0, eaddr: 0, edata: 8'h00, eelem: 0, ecyc: 120};
    vecs[1] = '{kind: 1, fa: 2, fb: 0, fv: 1'b1, efail: 1'b1, eaddr: 2, edata: 8'h01, eelem: 1, ecyc: 27};
    vecs[2] = '{kind: 2, fa: 1, fb: 0, fv: 1'b0, efail: 1'b1, eaddr: 1, edata: 8'hFF, eelem: 3, ecyc: 75};

    rstn = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    check_idle("reset");
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_fail", 32'(fail), 32'd0);
    chk("reset_fail_addr", 32'(fail_addr), 32'd0);
    chk("reset_idata", 32'(idata), 32'd0);
    $display("reset: csb=%0d ce=%0d web=%0d oeb=%0d busy=%0d done=%0d", csb, ce, web, oeb, busy, done);

    for (int i = 0; i < 3; i++) begin
      f_kind = vecs[i].kind; f_addr = vecs[i].fa; f_bit = vecs[i].fb; f_val = vecs[i].fv;
      model_run(ef, ea, ed, ee, ecyc);
      run_check($sformatf("vec%0d", i), -1, vecs[i].efail, vecs[i].eaddr, vecs[i].edata,
                vecs[i].eelem, vecs[i].ecyc);
    end

    // Start pulse mid-run is ignored; reset mid-run aborts; a fresh start then runs cleanly.
    f_kind = 0;
    model_run(ef, ea, ed, ee, ecyc);
    run_check("restart_ignored", 40, 1'b0, 0, 8'h00, 0, 120);
    model_run(ef, ea, ed, ee, ecyc);
    mon_en = 1'b1;
    do_run(-1, 60, cyc, ab);
    chk("abort_taken", 32'(ab), 32'd1);
    mon_en = 1'b0;
    $display("run abort: reset at busy cycle %0d", cyc);
    model_run(ef, ea, ed, ee, ecyc);
    run_check("after_abort", -1, 1'b0, 0, 8'h00, 0, 120);

    for (int i = 0; i < 8; i++) begin
      f_kind = int'($urandom_range(0, 2));
      f_addr = int'($urandom_range(0, AMAX));
      f_bit  = int'($urandom_range(0, 7));
      f_val  = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 4)) @(negedge clk);
      model_run(ef, ea, ed, ee, ecyc);
      run_check($sformatf("rand%0d", i), -1, ef, ea, ed, ee, ecyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
